// File: rtl/segment_recover.sv
// Recovers a segment vector from a serial pixel stream: watermarked and background
// pixels are dropped, each segment is decided by strict majority of its lit pixels.
module segment_recover #(
    parameter int WIDTH              = 120,
    parameter int HEIGHT             = 52,
    parameter int BITMAP_NB_SEGMENTS = 32,
    parameter int SEG_IDX_W          = 6,
    parameter int CNT_W              = 13
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_pix,
    input  logic [SEG_IDX_W-1:0]          in_seg,
    input  logic                          in_wm,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BITMAP_NB_SEGMENTS-1:0] out_seg,
    output logic                          out_err
);
    localparam int N     = BITMAP_NB_SEGMENTS;
    localparam int FRAME = WIDTH * HEIGHT;
    localparam int PIX_W = $clog2(FRAME + 1);
    localparam logic [PIX_W-1:0]     LAST_IDX = PIX_W'(FRAME - 1);
    localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // the result transfers on a rising edge where out_valid && out_ready.
    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, OUTPUT} state_t;

    state_t               state, next_state;
    logic [CNT_W-1:0]     lit [N];
    logic [CNT_W-1:0]     tot [N];
    logic [PIX_W-1:0]     pix_cnt;
    logic [SEG_IDX_W-1:0] idx;
    logic                 accept, at_limit, frame_end;

    assign accept    = in_valid && in_ready;
    assign at_limit  = (pix_cnt == LAST_IDX);
    assign frame_end = accept && (in_last || at_limit);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE:   if (start) next_state = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (frame_end) next_state = DECIDE;
            end
            DECIDE: if (idx == LAST_SEG) next_state = OUTPUT;
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                lit[i] <= '0;
                tot[i] <= '0;
            end
            pix_cnt <= '0;
            idx     <= '0;
            out_seg <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int i = 0; i < N; i++) begin
                        lit[i] <= '0;
                        tot[i] <= '0;
                    end
                    pix_cnt <= '0;
                    idx     <= '0;
                    out_seg <= '0;
                    out_err <= 1'b0;
                end
                ACCUM: if (accept) begin
                    pix_cnt <= pix_cnt + 1'b1;
                    // Background IDs never match any i < N, so they only advance pix_cnt.
                    for (int i = 0; i < N; i++) begin
                        if (!in_wm && in_seg == SEG_IDX_W'(i)) begin
                            if (tot[i] != CNT_MAX) tot[i] <= tot[i] + 1'b1;
                            if (in_pix && lit[i] != CNT_MAX) lit[i] <= lit[i] + 1'b1;
                        end
                    end
                    if (frame_end) begin
                        out_err <= !(in_last && at_limit);
                        idx     <= '0;
                    end
                end
                DECIDE: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == SEG_IDX_W'(i))
                            out_seg[i] <= ({lit[i], 1'b0} > {1'b0, tot[i]});
                    end
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_segment_recover.sv
// Scoreboard bench for segment_recover: a reference vote model pushes the expected
// {err, seg} per frame, and the result handshake pops and compares it.
module tb_segment_recover;
    localparam int W = 4, H = 2, N = 3, SW = 2, CW = 4;
    localparam int FRAME = W * H;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic          in_valid = 1'b0, in_pix = 1'b0, in_wm = 1'b0, in_last = 1'b0;
    logic [SW-1:0] in_seg = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_err;
    logic [N-1:0]  out_seg;

    segment_recover #(.WIDTH(W), .HEIGHT(H), .BITMAP_NB_SEGMENTS(N), .SEG_IDX_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .in_seg(in_seg), .in_wm(in_wm), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_seg(out_seg), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    logic [N:0]    exp_q[$];
    bit            q_pix[$], q_wm[$], q_last[$];
    logic [SW-1:0] q_seg[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_beats();
        q_pix.delete(); q_wm.delete(); q_last.delete(); q_seg.delete();
    endtask

    task automatic add(input bit p, input logic [SW-1:0] s, input bit w, input bit l);
        q_pix.push_back(p); q_seg.push_back(s); q_wm.push_back(w); q_last.push_back(l);
    endtask

    task automatic load_s1(input bit with_last);
        clear_beats();
        add(1, 0, 0, 0); add(0, 1, 0, 0); add(1, 2, 0, 0); add(1, 0, 0, 0);
        add(0, 1, 0, 0); add(1, 2, 0, 0); add(0, 0, 0, 0); add(1, 2, 0, with_last);
    endtask

    // Reference vote over the beat queues; returns the index of the frame-ending beat.
    task automatic model(output int end_idx);
        int lit[N], tot[N];
        logic [N:0] r;
        for (int s = 0; s < N; s++) begin lit[s] = 0; tot[s] = 0; end
        end_idx = -1;
        for (int i = 0; i < q_pix.size(); i++) begin
            if (end_idx < 0) begin
                if (!q_wm[i] && int'(q_seg[i]) < N) begin
                    if (tot[q_seg[i]] < CMAX) tot[q_seg[i]]++;
                    if (q_pix[i] && lit[q_seg[i]] < CMAX) lit[q_seg[i]]++;
                end
                if (q_last[i] || i == FRAME - 1) end_idx = i;
            end
        end
        r = '0;
        for (int s = 0; s < N; s++) r[s] = (2 * lit[s] > tot[s]);
        r[N] = !(q_last[end_idx] && end_idx == FRAME - 1);
        exp_q.push_back(r);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic drive_frame(input bit gaps, output int beat_cyc);
        int end_idx;
        model(end_idx);
        beat_cyc = cyc;
        pulse_start();
        for (int i = 0; i <= end_idx; i++) begin
            int  stalls = 0;
            bit  done = 0;
            while (!done) begin
                in_pix = q_pix[i]; in_seg = q_seg[i]; in_wm = q_wm[i]; in_last = q_last[i];
                in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                if (in_valid && in_ready) begin
                    done = 1; beat_cyc = cyc;
                end else if (in_valid) begin
                    stalls++;
                    if (stalls > 4) begin
                        check("in_ready_timeout", int'(in_ready), 1);
                        in_valid = 1'b0;
                        return;
                    end
                end
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1; in_pix = 1'b1; in_seg = '0; in_wm = 1'b0; in_last = 1'b0;
        check("ready_after_end", int'(in_ready), 0);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int beat_cyc, input int hold, input bit poke_start);
        int waited = 0;
        logic [N:0] e;
        while (!out_valid && waited < N + 4) begin @(posedge clk); #1; waited++; end
        if (!out_valid) begin
            check("out_valid_timeout", int'(out_valid), 1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
            return;
        end
        check("latency", cyc - beat_cyc, N + 1);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            check("hold_seg", int'(out_seg), int'(exp_q[0][N-1:0]));
            check("hold_valid", int'(out_valid), 1);
            if (poke_start && k == 2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        e = exp_q.pop_front();
        check("out_valid", int'(out_valid), 1);
        check("out_seg", int'(out_seg), int'(e[N-1:0]));
        check("out_err", int'(out_err), int'(e[N]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", int'(out_valid), 0);
        @(posedge clk); #1;
        check("idle_ready", int'(in_ready), 0);
    endtask

    task automatic run(input bit gaps, input int hold, input bit poke_start);
        int bc;
        drive_frame(gaps, bc);
        collect(bc, hold, poke_start);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_seg", int'(out_seg), 0);
        check("rst_out_err", int'(out_err), 0);
        rst_n = 1'b1;

        // basic majority vote
        load_s1(1); run(0, 0, 0);

        // tie on seg0, fully watermarked seg1
        clear_beats();
        add(1, 0, 0, 0); add(1, 1, 1, 0); add(0, 0, 0, 0); add(1, 1, 1, 0);
        add(1, 2, 0, 0); add(1, 1, 1, 0); add(0, 2, 0, 0); add(1, 2, 0, 1);
        run(0, 0, 0);

        // early in_last, trailing beats must be refused
        clear_beats();
        add(1, 0, 0, 0); add(1, 0, 0, 0); add(1, 1, 0, 0); add(0, 2, 0, 0);
        add(0, 1, 0, 1); add(1, 2, 0, 0); add(1, 2, 0, 0); add(1, 2, 0, 0);
        run(0, 0, 0);

        // full-length frame without in_last
        load_s1(0); run(0, 0, 0);

        // background beats
        clear_beats();
        add(1, 3, 0, 0); add(0, 0, 0, 0); add(1, 3, 0, 0); add(1, 1, 0, 0);
        add(1, 3, 0, 0); add(0, 2, 0, 0); add(1, 3, 0, 0); add(0, 2, 0, 1);
        run(0, 0, 0);

        // random in_valid gaps
        load_s1(1); run(1, 0, 0);

        // back-pressure with a stray start during OUTPUT
        load_s1(1); run(0, 10, 1);

        // reset in the middle of a frame
        load_s1(1);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pix = q_pix[i]; in_seg = q_seg[i]; in_wm = 1'b0; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_seg", int'(out_seg), 0);
        check("mid_rst_out_err", int'(out_err), 0);
        run(0, 0, 0);

        // random frames
        for (int f = 0; f < 4; f++) begin
            clear_beats();
            for (int i = 0; i < FRAME; i++)
                add(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0), (i == FRAME - 1) ? 1'b1 : ($urandom_range(0, 9) == 0));
            run(f[0], 0, 0);
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
